// File: rtl/dma_copy.sv
// dma_copy: byte-by-byte memory-to-memory copy engine on memory_bus.
//
// Requests the bus from an external arbiter, then for each byte performs a
// read (one setup cycle plus a capture cycle) followed by a write. Both the
// capture and the write stall while bus_halt is high. Source and destination
// addresses wrap modulo 2^24.
//
// Handshakes:
//   start/done   : start is a one-cycle pulse accepted only in IDLE. done is a
//                  one-cycle pulse, registered, seen in the cycle after the last
//                  write completes (remaining already reads 0 then).
//   request/grant: bus_request is held from the accepted start until IDLE.
//                  bus_grant is only looked at in REQUEST, and the arbiter must
//                  keep it high while bus_request is high.
//   bus_halt     : when high, the current read capture or write is held with
//                  address, data_out, bus_enable and write_enable stable.
//
// Ports:
//   clk, reset (async, active-low)
//   start, src_address, dst_address, length, abort   - control inputs
//   busy, done, aborted, remaining                   - status outputs
//   bus_request, bus_grant                           - arbitration
//   address, data_out, data_in, bus_enable,
//   write_enable, bus_halt                           - memory_bus side
//   dbg_state                                        - current FSM state
module dma_copy #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [23:0]          src_address,
    input  logic [23:0]          dst_address,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LEN_WIDTH-1:0] remaining,
    output logic                 bus_request,
    input  logic                 bus_grant,
    output logic [23:0]          address,
    output logic [7:0]           data_out,
    input  logic [7:0]           data_in,
    output logic                 bus_enable,
    output logic                 write_enable,
    input  logic                 bus_halt,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQUEST      = 3'd1,
        READ_SETUP   = 3'd2,
        READ_CAPTURE = 3'd3,
        WRITE        = 3'd4,
        NEXT         = 3'd5
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [23:0]          src;
    logic [23:0]          dst;
    logic [LEN_WIDTH-1:0] count;
    logic [7:0]           latch;
    logic                 done_r;
    logic                 aborted_r;
    logic                 last_byte;

    assign last_byte = (count == LEN_WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort overrides every transition out of a busy state,
    // including the final NEXT, so aborted and done can never both pulse.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && (length != '0)) next_state = REQUEST;
            end
            REQUEST: begin
                if (bus_grant) next_state = READ_SETUP;
            end
            READ_SETUP: begin
                next_state = READ_CAPTURE;
            end
            READ_CAPTURE: begin
                if (!bus_halt) next_state = WRITE;
            end
            WRITE: begin
                if (!bus_halt) next_state = NEXT;
            end
            NEXT: begin
                next_state = last_byte ? IDLE : READ_SETUP;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) next_state = IDLE;
    end

    // Datapath and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src       <= '0;
            dst       <= '0;
            count     <= '0;
            latch     <= '0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (length != '0) begin
                        src   <= src_address;
                        dst   <= dst_address;
                        count <= length;
                    end else begin
                        // Empty copy: report completion without touching the bus.
                        done_r <= 1'b1;
                    end
                end
            end else if (abort) begin
                aborted_r <= 1'b1;
            end else begin
                case (state)
                    READ_CAPTURE: begin
                        if (!bus_halt) latch <= data_in;
                    end
                    NEXT: begin
                        src   <= src + 24'd1;
                        dst   <= dst + 24'd1;
                        count <= count - LEN_WIDTH'(1);
                        if (last_byte) done_r <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Bus outputs are decoded from the state; address and data_out may show
    // stale register values when bus_enable is low.
    always_comb begin
        bus_enable   = (state == READ_SETUP) || (state == READ_CAPTURE) || (state == WRITE);
        write_enable = (state == WRITE);
        address      = (state == WRITE) ? dst : src;
    end

    assign data_out    = latch;
    assign busy        = (state != IDLE);
    assign bus_request = (state != IDLE);
    assign done        = done_r;
    assign aborted     = aborted_r;
    assign remaining   = count;
    assign dbg_state   = state;

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: self-checking bench for dma_copy.
//
// A byte-addressed memory model answers the bus on the falling edge, an
// arbiter grants after a configurable delay, and a halt generator stretches
// read captures and writes by configurable counts. Each copy's expected
// write sequence (address dst+i, data = memory[src+i]) and done latency
// (1 + len * (4 + read halt + write halt) cycles after grant is raised) are
// computed from the copy parameters alone.
module tb_dma_copy;

    localparam int LW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [23:0]   src_address;
    logic [23:0]   dst_address;
    logic [LW-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] remaining;
    logic          bus_request;
    logic          bus_grant;
    logic [23:0]   address;
    logic [7:0]    data_out;
    logic [7:0]    data_in;
    logic          bus_enable;
    logic          write_enable;
    logic          bus_halt;
    logic [2:0]    dbg_state;

    dma_copy #(.LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_address  (src_address),
        .dst_address  (dst_address),
        .length       (length),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .remaining    (remaining),
        .bus_request  (bus_request),
        .bus_grant    (bus_grant),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .bus_halt     (bus_halt),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [logic [23:0]];
    logic [23:0] exp_a_q[$];
    logic [7:0]  exp_d_q[$];
    logic [23:0] wr_a_q[$];
    logic [7:0]  wr_d_q[$];

    int hr_cfg = 0;      // read-capture halt cycles per byte
    int hw_cfg = 0;      // write halt cycles per byte
    int gnt_dly = 0;     // arbiter delay in cycles
    int grant_cyc = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int gcnt = 0;
    logic br_seen = 1'b0;
    logic be_seen = 1'b0;
    logic prev_halt = 1'b0;
    logic prev_be = 1'b0;
    logic [33:0] prev_sig = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // ---------------- memory, arbiter, halt generator ----------------
    always @(negedge clk) begin
        if (!reset) begin
            rd_cycles = 0;
            wr_cycles = 0;
            gcnt      = 0;
            bus_grant = 1'b0;
            bus_halt  = 1'b0;
            prev_halt = 1'b0;
            prev_be   = 1'b0;
        end else begin
            // A halted edge must leave the bus cycle unchanged.
            if (prev_halt && prev_be && !aborted)
                chk("halt_stable", {address, bus_enable, write_enable, data_out & {8{write_enable}}}, prev_sig);
            if (bus_enable || write_enable)
                chk("bus_needs_request", bus_request, 1'b1);

            rd_cycles = (bus_enable && !write_enable) ? rd_cycles + 1 : 0;
            wr_cycles = (bus_enable && write_enable) ? wr_cycles + 1 : 0;
            bus_halt  = (rd_cycles >= 2 && rd_cycles < 2 + hr_cfg) ||
                        (wr_cycles >= 1 && wr_cycles <= hw_cfg);

            if (bus_enable && !write_enable) data_in = rd(address);
            if (bus_enable && write_enable && !bus_halt) begin
                mem[address] = data_out;
                wr_a_q.push_back(address);
                wr_d_q.push_back(data_out);
            end

            if (!bus_request) begin
                bus_grant = 1'b0;
                gcnt      = 0;
            end else if (!bus_grant) begin
                if (gcnt >= gnt_dly) begin
                    bus_grant = 1'b1;
                    grant_cyc = cyc;
                end else begin
                    gcnt++;
                end
            end

            if (bus_request) br_seen = 1'b1;
            if (bus_enable)  be_seen = 1'b1;
            prev_halt = bus_halt;
            prev_be   = bus_enable;
            prev_sig  = {address, bus_enable, write_enable, data_out & {8{write_enable}}};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_aborted"}, aborted, 1'b0);
        chk({tag, "_remaining"}, remaining, 0);
        chk({tag, "_bus_request"}, bus_request, 1'b0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_bus_enable"}, bus_enable, 1'b0);
        chk({tag, "_write_enable"}, write_enable, 1'b0);
    endtask

    // mode 0: plain copy; 1: extra start pulse while busy; 2: abort in 3rd write
    task automatic run_copy(input logic [23:0] s, input logic [23:0] d, input int len, input int mode);
        int   n;
        int   wseen;
        logic got_done;
        logic got_abort;
        int   done_cyc;
        exp_a_q.delete();
        exp_d_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_a_q.push_back(d + 24'(i));
            exp_d_q.push_back(rd(s + 24'(i)));
        end
        @(negedge clk);
        wr_a_q.delete();
        wr_d_q.delete();
        start       = 1'b1;
        src_address = s;
        dst_address = d;
        length      = LW'(len);
        n = 0; wseen = 0; got_done = 0; got_abort = 0; done_cyc = 0;
        while (n < 4000) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_start", busy, 1'b1);
            if (done)    begin got_done = 1'b1; done_cyc = cyc; break; end
            if (aborted) begin got_abort = 1'b1; break; end
            if (mode == 1 && n == 6) begin
                start       = 1'b1;
                src_address = 24'h123456;
                dst_address = 24'h00F000;
                length      = LW'(9);
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && !abort && wr_a_q.size() == 2 && write_enable) begin
                wseen++;
                if (wseen == 2) abort = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (n >= 4000) chk("timeout", 0, 1);
        if (mode == 2) begin
            chk("abort_pulse", got_abort, 1'b1);
            chk("abort_no_done", got_done, 1'b0);
            chk("abort_we_low", write_enable, 1'b0);
            chk("abort_busy_low", busy, 1'b0);
            chk("abort_req_low", bus_request, 1'b0);
            chk("abort_remaining", remaining, LW'(len - 2));
            chk("abort_wr_count", wr_a_q.size(), 2);
            for (int i = 2; i < len; i++) chk("abort_untouched", mem.exists(d + 24'(i)), 0);
            @(negedge clk);
            chk("abort_pulse_end", aborted, 1'b0);
            chk("abort_no_late_done", done, 1'b0);
        end else begin
            chk("done_pulse", got_done, 1'b1);
            chk("done_latency", done_cyc - grant_cyc, 1 + len * (4 + hr_cfg + hw_cfg));
            chk("done_remaining", remaining, 0);
            chk("done_busy_low", busy, 1'b0);
            chk("done_req_low", bus_request, 1'b0);
            chk("wr_count", wr_a_q.size(), exp_a_q.size());
            for (int i = 0; i < exp_a_q.size() && i < wr_a_q.size(); i++) begin
                chk("wr_addr", wr_a_q[i], exp_a_q[i]);
                chk("wr_data", wr_d_q[i], exp_d_q[i]);
            end
            @(negedge clk);
            chk("done_pulse_end", done, 1'b0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        src_address = '0; dst_address = '0; length = '0;
        bus_grant = 1'b0; bus_halt = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_state", dbg_state, 0);
        reset = 1'b1;
        @(negedge clk);

        // Flash-to-RAM copy, no halts.
        mem[24'h00C000] = 8'h11; mem[24'h00C001] = 8'h22;
        mem[24'h00C002] = 8'h33; mem[24'h00C003] = 8'h44;
        hr_cfg = 0; hw_cfg = 0; gnt_dly = 0;
        run_copy(24'h00C000, 24'h000100, 4, 0);
        chk("ram_100", mem[24'h000100], 8'h11);
        chk("ram_103", mem[24'h000103], 8'h44);

        // Same copy with 20 halt cycles on every read capture.
        hr_cfg = 20;
        run_copy(24'h00C000, 24'h000200, 4, 0);
        hr_cfg = 0;

        // Address wrap at the top of the 24-bit space.
        run_copy(24'hFFFFFE, 24'h0000FE, 3, 0);

        // Zero-length start: done next cycle, no bus activity.
        @(negedge clk);
        br_seen = 1'b0; be_seen = 1'b0;
        start = 1'b1; length = '0; src_address = 24'h00C000; dst_address = 24'h000300;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        @(negedge clk);
        chk("len0_done_end", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("len0_no_request", br_seen, 1'b0);
        chk("len0_no_enable", be_seen, 1'b0);
        chk("len0_ram", mem.exists(24'h000300), 0);

        // Abort during the third byte's held write.
        hw_cfg = 5; gnt_dly = 2;
        run_copy(24'h00C400, 24'h000400, 8, 2);
        hw_cfg = 0;

        // Reset mid-READ_CAPTURE, then a copy with a stray start while busy.
        hr_cfg = 5; gnt_dly = 0;
        @(negedge clk);
        start = 1'b1; src_address = 24'hC00100; dst_address = 24'h002000; length = LW'(3);
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (rd_cycles < 2 && k < 100) begin @(negedge clk); k++; end
            if (k >= 100) chk("reach_capture_timeout", 0, 1);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        hr_cfg = 0;
        run_copy(24'hC00100, 24'h002000, 3, 1);

        // Randomized copies.
        for (int t = 0; t < 8; t++) begin
            hr_cfg  = $urandom_range(0, 3);
            hw_cfg  = $urandom_range(0, 2);
            gnt_dly = $urandom_range(0, 3);
            run_copy(24'h400000 + 24'($urandom_range(0, 24'h0FFFFF)),
                     24'h010000 + 24'($urandom_range(0, 24'h00FFFF)),
                     $urandom_range(1, 7), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
